// File: rtl/key_pkg.sv
// Shared types and constants for the PS/2 key controller slice.
package key_pkg;

    // Receiver frame position.
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Status word layout.
    localparam int VALID_BIT = 15;
    localparam int OVF_BIT   = 14;
    localparam int ERR_BIT   = 13;
    localparam int OCC_LSB   = 8;
    localparam int OCC_W     = 5;

    // Command word bits.
    localparam int CMD_POP   = 0;
    localparam int CMD_CLR   = 1;
    localparam int CMD_FLUSH = 2;

    // Absolute CPU address of the key port; decoding happens upstream.
    localparam logic [15:0] KEY_ADDR = 16'hFFFF;

endpackage

// File: rtl/key_fifo.sv
// 8-bit synchronous FIFO for scan codes with push, pop and flush.
// Flush beats push/pop; a push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle.
module key_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          dropped
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Resolve push/pop/flush into pointer and occupancy updates.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty && !flush;
        do_push  = push && !flush && (!full || do_pop);
        dropped  = push && !flush && full && !do_pop;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port.
    // NOTE: the array has no reset; empty entries are never read because head is masked when empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver behind the CPU key port: synchronises the PS/2
// lines, deserialises and checks frames, queues good scan codes and
// exposes head code plus status as a 16-bit read word.
module ps2_key_controller
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        wenable,
    output logic [15:0] rdata,
    output logic        key_available
);

    localparam int            TW           = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam int            CW           = $clog2(FIFO_DEPTH + 1);

    // Synchroniser chains; idle-high lines reset to 1 so no edge appears at reset release.
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   clk_s, data_s, fall;

    // Receiver state.
    rx_state_t     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          push_q, push_d;
    logic [7:0]    code_q, code_d;
    logic          err_set;

    // Flags and command decode.
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          cmd_hit, cmd_pop, cmd_clr, cmd_flush;

    // FIFO interface.
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty, fifo_dropped;
    logic [CW-1:0] fifo_count;

    // Upper command bits and the absolute port address are not decoded here.
    logic unused_bits;
    assign unused_bits = ^{wdata[15:3], KEY_ADDR, fifo_full};

    // Shift the raw PS/2 lines through the synchronisers.
    always_comb begin
        clk_sync_d    = clk_sync_q;
        dat_sync_d    = dat_sync_q;
        clk_sync_d[0] = ps2_clk;
        dat_sync_d[0] = ps2_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync_d[i] = clk_sync_q[i-1];
            dat_sync_d[i] = dat_sync_q[i-1];
        end
        clk_prev_d = clk_s;
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = dat_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q && !clk_s;

    // Synchroniser and edge-detect registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    // Frame receiver next state: bits sampled on synced falling edges, with an idle timeout mid-frame.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        timer_d   = '0;
        push_d    = 1'b0;
        code_d    = code_q;
        err_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fall && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && (^{shift_q, parity_q})) begin
                        push_d = 1'b1;
                        code_d = shift_q;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon a stalled frame; any edge restarts the count.
        if (state_q != IDLE && !fall) begin
            if (timer_q == TIMEOUT_LAST) begin
                state_d = IDLE;
                err_set = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // Receiver registers, including the one-cycle-delayed push strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            timer_q   <= '0;
            push_q    <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            timer_q   <= timer_d;
            push_q    <= push_d;
            code_q    <= code_d;
        end
    end

    // Command decode and sticky flags; a set event beats a same-cycle clear.
    always_comb begin
        cmd_hit   = wenable && (waddr == 16'h0000);
        cmd_pop   = cmd_hit && wdata[CMD_POP];
        cmd_clr   = cmd_hit && wdata[CMD_CLR];
        cmd_flush = cmd_hit && wdata[CMD_FLUSH];
        ovf_d     = fifo_dropped || (ovf_q && !cmd_clr);
        err_d     = err_set || (err_q && !cmd_clr);
    end

    // Sticky flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push_q),
        .push_data(code_q),
        .pop      (cmd_pop),
        .flush    (cmd_flush),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .dropped  (fifo_dropped)
    );

    // Assemble the status/data word from registered state.
    always_comb begin
        rdata                           = '0;
        rdata[VALID_BIT]                = !fifo_empty;
        rdata[OVF_BIT]                  = ovf_q;
        rdata[ERR_BIT]                  = err_q;
        rdata[OCC_LSB +: OCC_W]         = OCC_W'(fifo_count);
        rdata[7:0]                      = fifo_head;
    end

    assign key_available = !fifo_empty;

endmodule

// File: doc/ps2_key_controller.md
Name: ps2_key_controller

Overview:
- PS/2 keyboard receiver that sits directly downstream of the memory controller's key I/O port (address 16'hFFFF).
- Deserialises PS/2 device frames and checks start, parity and stop bits.
- Buffers valid scan codes in a FIFO and presents the head entry plus status as a 16-bit read word.
- CPU writes to 16'hFFFF pop, flush, or clear flags.

Parameters:
- FIFO_DEPTH, 16: scan-code entries. Power of two, at most 16.
- TIMEOUT_CYCLES, 50000: clock cycles without a PS/2 falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flops in the ps2_clk/ps2_data synchronisers.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- waddr  in  16  write address offset from the memory controller; only 0 is decoded.
- wdata  in  16  command word.
- wenable  in  1  write strobe, already qualified for address 16'hFFFF.
- rdata  out  16  status/data word.
- key_available  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset: all outputs 0; FIFO empty; sticky flags clear; receiver in IDLE. Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data pass through SYNC_STAGES synchronisers.
  - A falling edge is synced clk 1 then 0 on consecutive cycles.
  - Bits are sampled only on the falling-edge cycle.
- Receiver FSM:
  - IDLE: on an edge with data=0 (start bit), go to DATA and clear the bit counter. An edge with data=1 stays in IDLE.
  - DATA: shift in LSB-first; after the 8th bit go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: the frame is good if stop=1 and the 9 bits have odd parity. Good frame: push the code. Bad frame: no push; set frame_err. Either way return to IDLE.
  - Timeout: any state other than IDLE with TIMEOUT_CYCLES consecutive cycles without an edge returns to IDLE and sets frame_err. The idle counter resets on every edge.
- Push timing: the push occurs on the cycle after the stop-bit edge is detected. rdata reflects it on the following cycle.
- FIFO:
  - Push when full: the code is dropped and the overflow flag is set.
  - Pop when empty: no-op.
  - Simultaneous push and pop while non-empty: both happen, count unchanged.
  - Simultaneous push and pop while empty: the push is kept.
  - Pointers wrap modulo FIFO_DEPTH.
- rdata (registered from FIFO/flag state, combinational from those registers):
  - [15] valid (FIFO non-empty)
  - [14] overflow (sticky)
  - [13] frame_err (sticky)
  - [12:8] occupancy, 0..16
  - [7:0] head code, or 8'h00 when empty
- Write command, on wenable && waddr==0:
  - wdata[0]: pop.
  - wdata[1]: clear the overflow and frame_err flags. A set event in the same cycle wins.
  - wdata[2]: flush, which empties the FIFO. A flush has priority over a same-cycle push or pop.
  - Other bits are ignored.
- Writes with waddr≠0 are ignored.
- key_available equals rdata[15].

Decomposition:
- Package key_pkg:
  - rx_state_t enum (IDLE, DATA, PARITY, STOP)
  - status bit index constants (VALID_BIT=15, OVF_BIT=14, ERR_BIT=13)
  - command bit constants (CMD_POP=0, CMD_CLR=1, CMD_FLUSH=2)
  - KEY_ADDR = 16'hFFFF
- One sub-module, key_fifo: 8-bit synchronous FIFO with push, pop, flush, full/empty and count outputs.
- Synchroniser, edge detect, FSM and command decode stay in the top module.

Test Plan:
- Reset, then frame 0x1C (start 0, data 00111000 LSB-first, parity 0, stop 1) -> rdata=16'h811C and key_available=1 two cycles after the stop edge.
- From that state, write wdata=16'h0001 -> next cycle rdata=16'h0000 and key_available=0. A second pop leaves rdata=16'h0000.
- Frame 0x1C with parity bit 1 -> no push; rdata=16'h2000. Then write wdata=16'h0002 -> rdata=16'h0000.
- Send 17 frames, codes 0x01..0x11 -> rdata=16'hD001 (valid, overflow, count 16, head 0x01). Sixteen pops yield 0x01..0x10 in order; code 0x11 never appears.
- Five bits of a frame, then ps2_clk held high for TIMEOUT_CYCLES+10 -> no push and rdata=16'h2000. A following complete 0x5A frame -> rdata=16'hA15A.
- Assert reset_n=0 mid-frame after 4 data bits, release, then send 0x29 -> rdata=16'h8129 with no stale bits. Also: a push and a pop in the same cycle with count 3 leave count at 3.
